// File: rtl/float_oets_sorter_if.sv
// float_oets_sorter_if: input/output word streams of the block sorter
interface float_oets_sorter_if #(
    parameter int L = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [L-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [L-1:0] out_data;
    logic         out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/float_oets_sorter.sv
// float_oets_sorter: loads a block of floats, sorts it by odd-even transposition, drains it
module float_oets_sorter #(
    parameter int N     = 23,
    parameter int M     = 8,
    parameter int L     = N + M + 1,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 descend,
    input  logic                 flush,
    output logic                 busy,
    float_oets_sorter_if.slave   io
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

    state_t        state;
    logic [L-1:0]  mem [DEPTH];
    logic [L-1:0]  nxt [DEPTH];
    logic [CW-1:0] wr_cnt;
    logic [CW-1:0] rd_ptr;
    logic [CW-1:0] phase;
    logic [1:0]    clean;
    logic [1:0]    clean_next;
    logic          mode;
    logic          swapped;
    logic          sort_done;

    // Total-order key: negatives are bit-inverted, positives get the MSB set
    function automatic logic [L-1:0] key(input logic [L-1:0] w);
        return w[L-1] ? ~w : {1'b1, w[L-2:0]};
    endfunction

    assign io.in_ready  = state == LOAD;
    assign io.out_valid = state == DRAIN;
    assign io.out_last  = state == DRAIN && rd_ptr == CW'(DEPTH - 1);
    assign io.out_data  = mem[rd_ptr[AW-1:0]];
    assign busy         = state != LOAD;

    assign clean_next = swapped ? 2'd0 : clean + 2'd1;
    assign sort_done  = phase == CW'(DEPTH - 1) || clean_next == 2'd2;

    // One compare-exchange phase over the disjoint pairs selected by phase parity
    always_comb begin
        nxt     = mem;
        swapped = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (i[0] == phase[0] &&
                (mode ? key(mem[i]) < key(mem[i+1]) : key(mem[i]) > key(mem[i+1]))) begin
                nxt[i]   = mem[i+1];
                nxt[i+1] = mem[i];
                swapped  = 1'b1;
            end
        end
    end

    // Block FSM: load words, run phases until sorted, drain words
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= LOAD;
            wr_cnt <= '0;
            rd_ptr <= '0;
            phase  <= '0;
            clean  <= '0;
            mode   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            state  <= LOAD;
            wr_cnt <= '0;
            rd_ptr <= '0;
            phase  <= '0;
            clean  <= '0;
        end else begin
            case (state)
                LOAD: if (io.in_valid) begin
                    mem[wr_cnt[AW-1:0]] <= io.in_data;
                    wr_cnt <= wr_cnt + 1'b1;
                    if (wr_cnt == '0) mode <= descend;
                    if (wr_cnt == CW'(DEPTH - 1)) begin
                        state <= SORT;
                        phase <= '0;
                        clean <= '0;
                    end
                end
                SORT: begin
                    mem   <= nxt;
                    phase <= phase + 1'b1;
                    clean <= clean_next;
                    if (sort_done) begin
                        state  <= DRAIN;
                        rd_ptr <= '0;
                    end
                end
                DRAIN: if (io.out_ready) begin
                    rd_ptr <= rd_ptr + 1'b1;
                    if (rd_ptr == CW'(DEPTH - 1)) begin
                        state  <= LOAD;
                        wr_cnt <= '0;
                        rd_ptr <= '0;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_float_oets_sorter.sv
// tb_float_oets_sorter: directed checks of load, sort order, early exit, backpressure, flush, reset
module tb_float_oets_sorter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic descend = 1'b0;
    logic flush = 1'b0;
    logic busy;

    int total = 0;
    int bad = 0;

    logic [31:0] vec [8];
    logic [31:0] got [8];
    logic [7:0]  gl;
    int          gn;
    logic        desc_mode;

    float_oets_sorter_if #(.L(32)) io ();

    float_oets_sorter #(.N(23), .M(8), .DEPTH(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .descend (descend),
        .flush   (flush),
        .busy    (busy),
        .io      (io.slave)
    );

    always #5 clk = ~clk;

    task automatic load_block();
        for (int i = 0; i < 8; i++) begin
            io.in_valid = 1'b1;
            io.in_data  = vec[i];
            descend     = (i == 0) ? desc_mode : ~desc_mode;
            @(negedge clk);
        end
        io.in_valid = 1'b0;
        descend     = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!io.out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic drain_all();
        gn = 0;
        gl = '0;
        io.out_ready = 1'b1;
        for (int c = 0; c < 100 && gn < 8; c++) begin
            if (io.out_valid) begin
                got[gn] = io.out_data;
                gl[gn]  = io.out_last;
                gn++;
            end
            @(negedge clk);
        end
        io.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (io.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", io.in_ready); end
        total++; if (io.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", io.out_valid); end
        total++; if (io.out_last !== 1'b0) begin bad++; $display("FAIL rst_out_last got=%b exp=0", io.out_last); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        total++; if (io.out_data !== 32'h0) begin bad++; $display("FAIL rst_out_data got=%h exp=0", io.out_data); end
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (io.in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_in_ready got=%b exp=1", io.in_ready); end
    endtask

    task automatic test_ascending();
        logic [31:0] e [8];
        int lat;
        e   = '{32'hC0000000, 32'hBF800000, 32'h80000000, 32'h00000000,
                32'h3F000000, 32'h3F800000, 32'h40000000, 32'h7F800000};
        vec = '{32'h40000000, 32'hBF800000, 32'h3F800000, 32'h80000000,
                32'h7F800000, 32'h00000000, 32'hC0000000, 32'h3F000000};
        desc_mode = 1'b0;
        load_block();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL asc_busy got=%b exp=1", busy); end
        wait_valid(lat);
        drain_all();
        total++; if (gn !== 8) begin bad++; $display("FAIL asc_count got=%0d exp=8", gn); end
        for (int i = 0; i < 8; i++) begin
            total++; if (got[i] !== e[i]) begin bad++; $display("FAIL asc[%0d] got=%h exp=%h", i, got[i], e[i]); end
        end
        total++; if (gl !== 8'h80) begin bad++; $display("FAIL asc_last got=%b exp=10000000", gl); end
    endtask

    task automatic test_descending();
        logic [31:0] e [8];
        int lat;
        e   = '{32'h7F800000, 32'h40000000, 32'h3F800000, 32'h3F000000,
                32'h00000000, 32'h80000000, 32'hBF800000, 32'hC0000000};
        vec = '{32'h40000000, 32'hBF800000, 32'h3F800000, 32'h80000000,
                32'h7F800000, 32'h00000000, 32'hC0000000, 32'h3F000000};
        desc_mode = 1'b1;
        load_block();
        wait_valid(lat);
        drain_all();
        for (int i = 0; i < 8; i++) begin
            total++; if (got[i] !== e[i]) begin bad++; $display("FAIL desc[%0d] got=%h exp=%h", i, got[i], e[i]); end
        end
        total++; if (gl !== 8'h80) begin bad++; $display("FAIL desc_last got=%b exp=10000000", gl); end
    endtask

    task automatic test_early_exit();
        logic [31:0] e [8];
        int lat;
        e   = '{32'hC0000000, 32'hBF800000, 32'h80000000, 32'h00000000,
                32'h3F000000, 32'h3F800000, 32'h40000000, 32'h7F800000};
        vec = e;
        desc_mode = 1'b0;
        load_block();
        wait_valid(lat);
        total++; if (lat !== 2) begin bad++; $display("FAIL early_latency got=%0d exp=2", lat); end
        drain_all();
        for (int i = 0; i < 8; i++) begin
            total++; if (got[i] !== e[i]) begin bad++; $display("FAIL early[%0d] got=%h exp=%h", i, got[i], e[i]); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] e [8];
        int lat;
        e   = '{32'hC0000000, 32'hBF800000, 32'h80000000, 32'h00000000,
                32'h3F000000, 32'h3F800000, 32'h40000000, 32'h7F800000};
        vec = '{32'h40000000, 32'hBF800000, 32'h3F800000, 32'h80000000,
                32'h7F800000, 32'h00000000, 32'hC0000000, 32'h3F000000};
        desc_mode = 1'b0;
        load_block();
        wait_valid(lat);
        total++; if (io.out_valid !== 1'b1) begin bad++; $display("FAIL bp_timeout got=%b exp=1", io.out_valid); end
        for (int j = 0; j < 3; j++) begin
            total++; if (io.out_data !== e[j]) begin bad++; $display("FAIL bp_pre[%0d] got=%h exp=%h", j, io.out_data, e[j]); end
            io.out_ready = 1'b1;
            @(negedge clk);
        end
        io.out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++; if (io.out_valid !== 1'b1 || io.out_data !== e[3] || io.in_ready !== 1'b0) begin
                bad++; $display("FAIL bp_hold[%0d] got=%b/%h/%b exp=1/%h/0", c, io.out_valid, io.out_data, io.in_ready, e[3]);
            end
        end
        for (int j = 3; j < 8; j++) begin
            total++; if (io.out_data !== e[j] || io.out_last !== (j == 7) || io.in_ready !== 1'b0) begin
                bad++; $display("FAIL bp_post[%0d] got=%h/%b/%b exp=%h/%b/0", j, io.out_data, io.out_last, io.in_ready, e[j], j == 7);
            end
            io.out_ready = 1'b1;
            @(negedge clk);
        end
        io.out_ready = 1'b0;
        total++; if (io.in_ready !== 1'b1 || io.out_valid !== 1'b0) begin
            bad++; $display("FAIL bp_end got=%b/%b exp=1/0", io.in_ready, io.out_valid);
        end
    endtask

    task automatic test_duplicates();
        int lat;
        vec = '{32'h3F800000, 32'h00000000, 32'h3F800000, 32'h00000000,
                32'h3F800000, 32'h00000000, 32'h3F800000, 32'h00000000};
        desc_mode = 1'b0;
        load_block();
        wait_valid(lat);
        total++; if (lat > 8) begin bad++; $display("FAIL dup_latency got=%0d exp<=8", lat); end
        drain_all();
        for (int i = 0; i < 8; i++) begin
            total++; if (got[i] !== (i < 4 ? 32'h0 : 32'h3F800000)) begin
                bad++; $display("FAIL dup[%0d] got=%h exp=%h", i, got[i], i < 4 ? 32'h0 : 32'h3F800000);
            end
        end
    endtask

    task automatic test_flush();
        logic [31:0] e [8];
        int lat;
        vec = '{32'h40000000, 32'hBF800000, 32'h3F800000, 32'h80000000,
                32'h7F800000, 32'h00000000, 32'hC0000000, 32'h3F000000};
        for (int i = 0; i < 5; i++) begin
            io.in_valid = 1'b1;
            io.in_data  = vec[i];
            @(negedge clk);
        end
        io.in_data = 32'h12345678;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        io.in_valid = 1'b0;
        total++; if (io.in_ready !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL flush_state got=%b/%b exp=1/0", io.in_ready, busy);
        end
        vec = '{32'hFF800000, 32'h7FC00000, 32'hFFC00000, 32'h00000001,
                32'h80000001, 32'h7F7FFFFF, 32'h3F800000, 32'hBF000000};
        e   = '{32'hFFC00000, 32'hFF800000, 32'hBF000000, 32'h80000001,
                32'h00000001, 32'h3F800000, 32'h7F7FFFFF, 32'h7FC00000};
        desc_mode = 1'b0;
        load_block();
        wait_valid(lat);
        drain_all();
        for (int i = 0; i < 8; i++) begin
            total++; if (got[i] !== e[i]) begin bad++; $display("FAIL flush_blk[%0d] got=%h exp=%h", i, got[i], e[i]); end
        end
    endtask

    task automatic test_async_reset();
        int lat;
        vec = '{32'h40000000, 32'hBF800000, 32'h3F800000, 32'h80000000,
                32'h7F800000, 32'h00000000, 32'hC0000000, 32'h3F000000};
        desc_mode = 1'b0;
        load_block();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL ar_sorting got=%b exp=1", busy); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (io.in_ready !== 1'b1 || busy !== 1'b0 || io.out_valid !== 1'b0) begin
            bad++; $display("FAIL ar_immediate got=%b/%b/%b exp=1/0/0", io.in_ready, busy, io.out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (io.in_ready !== 1'b1 || io.out_valid !== 1'b0) begin
            bad++; $display("FAIL ar_after got=%b/%b exp=1/0", io.in_ready, io.out_valid);
        end
        vec = '{32'h3F800000, 32'h00000000, 32'h3F800000, 32'h00000000,
                32'h3F800000, 32'h00000000, 32'h3F800000, 32'h00000000};
        desc_mode = 1'b1;
        load_block();
        wait_valid(lat);
        drain_all();
        for (int i = 0; i < 8; i++) begin
            total++; if (got[i] !== (i < 4 ? 32'h3F800000 : 32'h0)) begin
                bad++; $display("FAIL ar_blk[%0d] got=%h exp=%h", i, got[i], i < 4 ? 32'h3F800000 : 32'h0);
            end
        end
    endtask

    initial begin
        io.in_valid  = 1'b0;
        io.in_data   = '0;
        io.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_ascending();
        test_descending();
        test_early_exit();
        test_backpressure();
        test_duplicates();
        test_flush();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
